// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 31x32 architectural register file, r0 hardwired to zero.
// Ports: clk, rst (sync, active-high); read ports A/B and a debug port;
// one write port (Wt_addr/Wt_data/L_S). WRITE_BYPASS forwards same-cycle
// write data to matching read ports; DEBUG_EN gates the debug port.
module reg_file_32x32 #(
    parameter bit WRITE_BYPASS = 1'b0,
    parameter bit DEBUG_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  R_addr_A,
    input  logic [4:0]  R_addr_B,
    input  logic [4:0]  Wt_addr,
    input  logic [31:0] Wt_data,
    input  logic        L_S,
    input  logic [4:0]  Debug_addr,
    output logic [31:0] rdata_A,
    output logic [31:0] rdata_B,
    output logic [31:0] Debug_data
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic        wr_en;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [31:0] rd_d;

    // Writes to r0 and writes colliding with reset are dropped here,
    // which also keeps them out of the bypass path.
    assign wr_en = L_S && !rst && (Wt_addr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (rst) begin
                regs_d[i] = '0;
            end else if (wr_en && (Wt_addr == 5'(i))) begin
                regs_d[i] = Wt_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Address 0 never matches a storage index, so it reads zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        rd_d = '0;
        for (int i = 1; i < 32; i++) begin
            if (R_addr_A == 5'(i)) begin
                rd_a = regs_q[i];
            end
            if (R_addr_B == 5'(i)) begin
                rd_b = regs_q[i];
            end
            if (Debug_addr == 5'(i)) begin
                rd_d = regs_q[i];
            end
        end
        if (WRITE_BYPASS && wr_en) begin
            if (R_addr_A == Wt_addr) begin
                rd_a = Wt_data;
            end
            if (R_addr_B == Wt_addr) begin
                rd_b = Wt_data;
            end
            if (Debug_addr == Wt_addr) begin
                rd_d = Wt_data;
            end
        end
    end

    assign rdata_A    = rd_a;
    assign rdata_B    = rd_b;
    assign Debug_data = DEBUG_EN ? rd_d : 32'h0;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed + randomized bench for reg_file_32x32.
// Three instances: no bypass, bypass, and debug disabled.
module tb_reg_file_32x32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ls;
    logic [4:0]  da;

    logic [31:0] a0, b0, d0;
    logic [31:0] a1, b1, d1;
    logic [31:0] a2, b2, d2;

    int errs = 0;
    int checks = 0;

    logic [31:0] mdl [0:31];

    always #5 clk = ~clk;

    reg_file_32x32 #(.WRITE_BYPASS(1'b0), .DEBUG_EN(1'b1)) u_nb (
        .clk(clk), .rst(rst), .R_addr_A(ra), .R_addr_B(rb),
        .Wt_addr(wa), .Wt_data(wd), .L_S(ls), .Debug_addr(da),
        .rdata_A(a0), .rdata_B(b0), .Debug_data(d0)
    );

    reg_file_32x32 #(.WRITE_BYPASS(1'b1), .DEBUG_EN(1'b1)) u_bp (
        .clk(clk), .rst(rst), .R_addr_A(ra), .R_addr_B(rb),
        .Wt_addr(wa), .Wt_data(wd), .L_S(ls), .Debug_addr(da),
        .rdata_A(a1), .rdata_B(b1), .Debug_data(d1)
    );

    reg_file_32x32 #(.WRITE_BYPASS(1'b0), .DEBUG_EN(1'b0)) u_nd (
        .clk(clk), .rst(rst), .R_addr_A(ra), .R_addr_B(rb),
        .Wt_addr(wa), .Wt_data(wd), .L_S(ls), .Debug_addr(da),
        .rdata_A(a2), .rdata_B(b2), .Debug_data(d2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                           input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && ls && !rst && wa != 5'd0 && wa == a) return wd;
        return mdl[a];
    endfunction

    // Advance one rising edge, update the reference model, settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (ls && wa != 5'd0) begin
            mdl[wa] = wd;
        end
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_nbA"}, a0, exp_rd(ra, 1'b0));
        chk({tag, "_nbB"}, b0, exp_rd(rb, 1'b0));
        chk({tag, "_nbD"}, d0, exp_rd(da, 1'b0));
        chk({tag, "_bpA"}, a1, exp_rd(ra, 1'b1));
        chk({tag, "_bpB"}, b1, exp_rd(rb, 1'b1));
        chk({tag, "_bpD"}, d1, exp_rd(da, 1'b1));
        chk({tag, "_ndD"}, d2, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst = 1'b1; ls = 1'b0; ra = '0; rb = '0;
        wa = '0; wd = '0; da = '0;
        tick();
        rst = 1'b0;
        ra = 5'd5; rb = 5'd31; da = 5'd17;
        #1;
        chk("rst_A", a0, 32'h0);
        chk("rst_B", b1, 32'h0);
        chk("rst_D", d0, 32'h0);

        // reset clears a written register
        ls = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        #1;
        chk("w5_pre_nb", a0, 32'h0);
        chk("w5_pre_bp", a1, 32'hDEAD_BEEF);
        tick();
        ls = 1'b0;
        #1;
        chk("w5_post", a0, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        chk("w5_rstpre", a0, 32'hDEAD_BEEF);
        tick();
        rst = 1'b0;
        #1;
        chk("w5_clr", a0, 32'h0);
        for (int i = 1; i < 32; i++) begin
            da = 5'(i);
            #1;
            chk("sweep", d0, 32'h0);
        end

        // plain write/read
        ls = 1'b1; wa = 5'd7; wd = 32'h1234_5678;
        ra = 5'd7; rb = 5'd7;
        #1;
        chk("w7_preA", a0, 32'h0);
        chk("w7_preB_bp", b1, 32'h1234_5678);
        tick();
        ls = 1'b0;
        #1;
        chk("w7_A", a0, 32'h1234_5678);
        chk("w7_B", b0, 32'h1234_5678);

        // writes to r0 are discarded, even with bypass
        ls = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        ra = 5'd0; rb = 5'd0; da = 5'd0;
        #1;
        chk("r0_pre_bpA", a1, 32'h0);
        chk("r0_pre_bpD", d1, 32'h0);
        tick();
        ls = 1'b0;
        #1;
        chk("r0_nbA", a0, 32'h0);
        chk("r0_nbB", b0, 32'h0);
        chk("r0_nbD", d0, 32'h0);
        chk("r0_bpA", a1, 32'h0);
        chk("r0_bpB", b1, 32'h0);

        // bypass on one port, stored value on the other
        ls = 1'b1; wa = 5'd4; wd = 32'h0000_0044;
        tick();
        wa = 5'd3; wd = 32'hA5A5_A5A5;
        ra = 5'd3; rb = 5'd4; da = 5'd3;
        #1;
        chk("byp_A", a1, 32'hA5A5_A5A5);
        chk("byp_B", b1, 32'h0000_0044);
        chk("byp_D", d1, 32'hA5A5_A5A5);
        chk("nbyp_A", a0, 32'h0);
        chk("nbyp_B", b0, 32'h0000_0044);
        chk("nodbg", d2, 32'h0);
        tick();
        ls = 1'b0;
        #1;
        chk("byp_post", a0, 32'hA5A5_A5A5);

        // reset beats a simultaneous write; bypass suppressed
        rst = 1'b1; ls = 1'b1; wa = 5'd9; wd = 32'h0000_0042;
        ra = 5'd9; rb = 5'd3;
        #1;
        chk("col_pre_bpA", a1, 32'h0);
        chk("col_pre_bpB", b1, 32'hA5A5_A5A5);
        tick();
        rst = 1'b0; ls = 1'b0;
        #1;
        chk("col_A", a0, 32'h0);
        chk("col_bpA", a1, 32'h0);
        chk("col_B", b0, 32'h0);

        // back-to-back writes, last wins
        ls = 1'b1; wa = 5'd10; wd = 32'h1; ra = 5'd10;
        tick();
        #1;
        chk("b2b_1", a0, 32'h1);
        wd = 32'h2;
        tick();
        ls = 1'b0;
        #1;
        chk("b2b_2", a0, 32'h2);

        // randomized regression against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            ls = $urandom_range(0, 1);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            da = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            #1;
            chk_all("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
